spi_regfile_stream: RTL and testbench

Parametrised register file with one write port, two asynchronous read ports, and an SPI mode-0 transmitter that serialises any selected register off-chip for debug and observation. It sits in the CPU datapath in place of the plain register file. The SPI side runs from the same clock and never stalls the core.

---
 rtl/spi_regfile_pkg.sv | 19 +
 rtl/spi_word_tx.sv | 88 ++++++++
 rtl/spi_regfile_stream.sv | 129 ++++++++++++
 tb/tb_spi_regfile_stream.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_regfile_pkg.sv
// Shared types and defaults for the SPI-observable register file.
// Optional feature macro used by the top: SPI_DUMP_ALL_EN.
package spi_regfile_pkg;

  localparam int DEF_W_DATA  = 32;
  localparam int DEF_DEPTH   = 32;
  localparam int DEF_CLK_DIV = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } tx_state_e;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/spi_word_tx.sv
// SPI mode-0 word transmitter: divider, bit counter, shift register and FSM.
// Frames are MSB first; a load in IDLE or DONE starts a new frame.
module spi_word_tx
  import spi_regfile_pkg::*;
#(
  parameter int W_DATA  = DEF_W_DATA,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [W_DATA-1:0] word,
  output logic              busy,
  output logic              cs_n,
  output logic              sclk,
  output logic              mosi,
  output logic              done
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(W_DATA + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W_DATA);

  tx_state_e         state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              sclk_q, sclk_d;
  logic [W_DATA-1:0] sh_q, sh_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    sh_d    = sh_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (load) begin
          state_d = SHIFT;
          sh_d    = word;
          div_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // Falling edge of sclk: advance to the next bit while sclk is low.
          if (sclk_q) begin
            sh_d  = {sh_q[W_DATA-2:0], 1'b0};
            bit_d = bit_q + 1'b1;
            if (bit_d == BIT_LAST) state_d = DONE;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == SHIFT);
  assign cs_n = ~busy;
  assign sclk = sclk_q;
  assign mosi = busy & sh_q[W_DATA-1];
  assign done = (state_q == DONE);

endmodule

// File: rtl/spi_regfile_stream.sv
// Register file (r0 hardwired to zero) with an SPI debug transmitter.
// Define SPI_DUMP_ALL_EN to add the spi_dump port that streams every register.
module spi_regfile_stream
  import spi_regfile_pkg::*;
#(
  parameter int W_DATA  = DEF_W_DATA,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wren,
  input  logic [addr_w(DEPTH)-1:0]  wa,
  input  logic [W_DATA-1:0]         wd,
  input  logic [addr_w(DEPTH)-1:0]  ra1,
  input  logic [addr_w(DEPTH)-1:0]  ra2,
  output logic [W_DATA-1:0]         rd1,
  output logic [W_DATA-1:0]         rd2,
  input  logic                      spi_start,
  input  logic [addr_w(DEPTH)-1:0]  spi_addr,
  output logic                      spi_busy,
  output logic                      spi_cs_n,
  output logic                      spi_sclk,
  output logic                      spi_out,
  output logic                      dv_spi
`ifdef SPI_DUMP_ALL_EN
  ,
  input  logic                      spi_dump
`endif
);

  localparam int AW = addr_w(DEPTH);

  logic [W_DATA-1:0] rf [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_rf
      if (gi == 0) begin : g_zero
        assign rf[gi] = '0;
      end else begin : g_reg
        logic [W_DATA-1:0] r_q, r_d;
        always_comb begin
          r_d = r_q;
          if (wren && (wa == AW'(gi))) r_d = wd;
        end
        always_ff @(posedge clk or posedge rst) begin
          if (rst) r_q <= '0;
          else     r_q <= r_d;
        end
        assign rf[gi] = r_q;
      end
    end
  endgenerate

  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];

  logic              tx_load;
  logic [W_DATA-1:0] tx_word;
  logic              tx_busy;
  logic              tx_done;

`ifdef SPI_DUMP_ALL_EN
  logic          dump_active_q, dump_active_d;
  logic [AW-1:0] dump_addr_q, dump_addr_d;
  logic          dump_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dump_active_q <= 1'b0;
      dump_addr_q   <= '0;
    end else begin
      dump_active_q <= dump_active_d;
      dump_addr_q   <= dump_addr_d;
    end
  end

  // dump_addr_q holds the next address to send; wrapping to 0 marks the last frame.
  always_comb begin
    dump_active_d = dump_active_q;
    dump_addr_d   = dump_addr_q;
    dump_end      = dump_active_q && tx_done && (dump_addr_q == '0);
    tx_load       = 1'b0;
    tx_word       = rf[spi_addr];
    if (!tx_busy && (!dump_active_q || dump_end)) begin
      if (spi_start) begin
        tx_load       = 1'b1;
        dump_active_d = 1'b0;
      end else if (spi_dump) begin
        tx_load       = 1'b1;
        tx_word       = rf[0];
        dump_active_d = 1'b1;
        dump_addr_d   = AW'(1);
      end else if (dump_end) begin
        dump_active_d = 1'b0;
      end
    end else if (dump_active_q && tx_done) begin
      tx_load     = 1'b1;
      tx_word     = rf[dump_addr_q];
      dump_addr_d = dump_addr_q + 1'b1;
    end
  end

  assign spi_busy = tx_busy | (dump_active_q & ~dump_end);
`else
  assign tx_load  = spi_start & ~tx_busy;
  assign tx_word  = rf[spi_addr];
  assign spi_busy = tx_busy;
`endif

  spi_word_tx #(
    .W_DATA  (W_DATA),
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .load (tx_load),
    .word (tx_word),
    .busy (tx_busy),
    .cs_n (spi_cs_n),
    .sclk (spi_sclk),
    .mosi (spi_out),
    .done (tx_done)
  );

  assign dv_spi = tx_done;

endmodule

// File: tb/tb_spi_regfile_stream.sv
// Scoreboard bench for spi_regfile_stream: stimulus pushes expected frames, a receiver
// monitor pops them on every dv_spi pulse. Dump scenario runs when SPI_DUMP_ALL_EN is defined.
module tb_spi_regfile_stream;

  localparam int W     = 32;
  localparam int D     = 32;
  localparam int CD    = 2;
  localparam int AW    = 5;
  localparam int FRAME = W * 2 * CD;

  logic          clk = 1'b0;
  logic          rst;
  logic          wren;
  logic [AW-1:0] wa;
  logic [W-1:0]  wd;
  logic [AW-1:0] ra1, ra2;
  logic [W-1:0]  rd1, rd2;
  logic          spi_start;
  logic [AW-1:0] spi_addr;
  logic          spi_busy, spi_cs_n, spi_sclk, spi_out, dv_spi;
`ifdef SPI_DUMP_ALL_EN
  logic          spi_dump;
`endif

  spi_regfile_stream #(.W_DATA(W), .DEPTH(D), .CLK_DIV(CD)) dut (
    .clk       (clk),
    .rst       (rst),
    .wren      (wren),
    .wa        (wa),
    .wd        (wd),
    .ra1       (ra1),
    .ra2       (ra2),
    .rd1       (rd1),
    .rd2       (rd2),
    .spi_start (spi_start),
    .spi_addr  (spi_addr),
    .spi_busy  (spi_busy),
    .spi_cs_n  (spi_cs_n),
    .spi_sclk  (spi_sclk),
    .spi_out   (spi_out),
    .dv_spi    (dv_spi)
`ifdef SPI_DUMP_ALL_EN
    ,
    .spi_dump  (spi_dump)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int frames_seen = 0;
  int frames_exp = 0;

  typedef struct {
    logic [31:0] word;
    int          dv_cyc;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%h want=%h (cyc %0d)", name, got, want, cyc);
    end
  endtask

  // Receiver model: samples spi_out on each sclk rising edge while cs_n is low.
  initial begin : monitor
    logic        prev_sclk;
    logic        prev_cs;
    logic [31:0] cap;
    int          nbits;
    int          low_cnt;
    exp_t        e;
    prev_sclk = 1'b0;
    prev_cs   = 1'b1;
    cap       = '0;
    nbits     = 0;
    low_cnt   = 0;
    forever begin
      @(negedge clk);
      if (!spi_cs_n && prev_cs) begin
        cap     = '0;
        nbits   = 0;
        low_cnt = 0;
      end
      if (!spi_cs_n) begin
        low_cnt++;
        if (spi_sclk && !prev_sclk) begin
          cap   = {cap[30:0], spi_out};
          nbits = nbits + 1;
        end
      end
      if (dv_spi) begin
        frames_seen++;
        if (exp_q.size() == 0) begin
          chk("dv_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("frame_word", cap, e.word);
          chk("frame_bits", 32'(nbits), 32'd32);
          chk("cs_low_cycles", 32'(low_cnt), 32'(FRAME));
          chk("dv_cycle", 32'(cyc), 32'(e.dv_cyc));
          $display("frame: word=%h exp=%h bits=%0d cs_low=%0d dv_cyc=%0d", cap, e.word, nbits, low_cnt, cyc);
        end
      end
      prev_sclk = spi_sclk;
      prev_cs   = spi_cs_n;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    wren = 1'b1;
    wa   = AW'(a);
    wd   = d;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic start(input int a, input logic [31:0] word, input bit push);
    exp_t e;
    spi_start = 1'b1;
    spi_addr  = AW'(a);
    if (push) begin
      e.word   = word;
      e.dv_cyc = cyc + FRAME + 1;
      exp_q.push_back(e);
      frames_exp++;
    end
    @(negedge clk);
    spi_start = 1'b0;
  endtask

  task automatic wait_dv(input int limit);
    int n;
    n = 0;
    while (!dv_spi && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!dv_spi) chk("dv_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    wren      = 1'b0;
    wa        = '0;
    wd        = '0;
    ra1       = '0;
    ra2       = '0;
    spi_start = 1'b0;
    spi_addr  = '0;
`ifdef SPI_DUMP_ALL_EN
    spi_dump  = 1'b0;
`endif
    tick(3);
    rst = 1'b0;
    tick(1);

    chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst_sclk", 32'(spi_sclk), 32'd0);
    chk("rst_out", 32'(spi_out), 32'd0);
    chk("rst_dv", 32'(dv_spi), 32'd0);
    chk("rst_busy", 32'(spi_busy), 32'd0);

    // Register writes, no bypass, r0 hardwired
    ra1  = 5;
    wren = 1'b1; wa = 5; wd = 32'hDEADBEEF;
    #1 chk("no_bypass", rd1, 32'h0);
    @(negedge clk);
    wren = 1'b0;
    chk("rd1_r5", rd1, 32'hDEADBEEF);
    wr(0, 32'h1234);
    ra2 = 0;
    #1 chk("rd2_r0", rd2, 32'h0);
    wr(9, 32'hA5A5_0F0F);
    ra2 = 9;
    #1 chk("rd2_r9", rd2, 32'hA5A5_0F0F);

    // Single frame of r5
    start(5, 32'hDEADBEEF, 1);
    chk("busy_in_frame", 32'(spi_busy), 32'd1);
    wait_dv(FRAME + 10);
    chk("busy_in_done", 32'(spi_busy), 32'd0);
    tick(3);

    // Mid-frame write and dropped start
    wr(7, 32'h0BAD_F00D);
    start(7, 32'h0BAD_F00D, 1);
    tick(20);
    wr(7, 32'hFFFFFFFF);
    tick(10);
    start(3, 32'h0, 0);
    wait_dv(FRAME + 10);
    tick(1);
    ra1 = 7;
    #1 chk("rd1_r7_new", rd1, 32'hFFFFFFFF);
    tick(FRAME + 20);

    // Start during DONE: back-to-back frames
    start(5, 32'hDEADBEEF, 1);
    wait_dv(FRAME + 10);
    start(7, 32'hFFFFFFFF, 1);
    chk("b2b_cs_low", 32'(spi_cs_n), 32'd0);
    wait_dv(FRAME + 10);
    tick(3);

    // Asynchronous reset during bit 10
    start(9, 32'hA5A5_0F0F, 1);
    tick(41);
    chk("pre_rst_cs_low", 32'(spi_cs_n), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("abort_cs_n", 32'(spi_cs_n), 32'd1);
    chk("abort_sclk", 32'(spi_sclk), 32'd0);
    chk("abort_busy", 32'(spi_busy), 32'd0);
    chk("abort_out", 32'(spi_out), 32'd0);
    exp_q.delete();
    frames_exp--;
    tick(2);
    rst = 1'b0;
    ra1 = 5;
    ra2 = 7;
    #1 chk("cleared_r5", rd1, 32'h0);
    chk("cleared_r7", rd2, 32'h0);
    tick(FRAME + 20);

`ifdef SPI_DUMP_ALL_EN
    // Dump every register in address order
    for (int n = 1; n < D; n++) wr(n, 32'(n) * 32'h01010101);
    begin
      exp_t e;
      for (int i = 0; i < D; i++) begin
        e.word   = 32'(i) * 32'h01010101;
        e.dv_cyc = cyc + (FRAME + 1) * (i + 1);
        exp_q.push_back(e);
        frames_exp++;
      end
    end
    spi_dump = 1'b1;
    @(negedge clk);
    spi_dump = 1'b0;
    for (int i = 0; i < D; i++) begin
      wait_dv(FRAME + 10);
      chk("dump_done_busy", 32'(spi_busy), (i == D - 1) ? 32'd0 : 32'd1);
      tick(1);
      if (i == 0) begin
        tick(10);
        start(3, 32'h0, 0);
      end
    end
    tick(1);
    chk("dump_idle_busy", 32'(spi_busy), 32'd0);
`endif

    tick(5);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("frame_count", 32'(frames_seen), 32'(frames_exp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
